ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Implements the full host request sequence:
  - inhibit the clock;
  - drive the start bit, then release the clock;
  - shift 8 data bits, odd parity and stop on device-generated clock falling edges;
  - check the device ACK bit.
- Drives the open-drain PS/2 lines through active-high "pull low" enables.
- tx_busy gates the existing PS/2 receiver so it does not decode its own traffic.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_sync_edge.sv | 37 +++
 rtl/ps2_host_tx.sv | 177 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes
// and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  localparam int unsigned TIMER_W = 20;

  // PS/2 uses odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the raw PS/2 clock and data pins, plus a
// falling-edge flag on the synchronised clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic clk_s0, clk_s1;
  logic data_s0, data_s1;

  // Reset to the idle (high) bus level so leaving reset never flags an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s0  <= 1'b1;
      clk_s1  <= 1'b1;
      data_s0 <= 1'b1;
      data_s1 <= 1'b1;
    end else begin
      clk_s0  <= ps2_clk_in;
      clk_s1  <= clk_s0;
      data_s0 <= ps2_data_in;
      data_s1 <= data_s0;
    end
  end

  always_comb begin
    clk_sync  = clk_s1;
    data_sync = data_s1;
    clk_fall  = clk_s1 & ~clk_s0;
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues the start bit,
// shifts one command byte on device clock edges and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES       = 5000,
  parameter int unsigned START_TIMEOUT_CYCLES = 750000,
  parameter int unsigned BIT_TIMEOUT_CYCLES   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST     = TIMER_W'(BIT_TIMEOUT_CYCLES - 1);

  ps2_tx_state_e      state, state_n;
  logic [9:0]         frame, frame_n;
  logic [3:0]         bit_idx, bit_idx_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic               ack_ok, ack_ok_n;
  logic               busy_n, done_n, error_n, clk_low_n, data_low_n;

  logic               clk_sync, data_sync, clk_fall;
  logic               expired;

  ps2_sync_edge u_sync (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .clk_fall    (clk_fall)
  );

  // Until the first device edge the long start timeout applies, then the bit gap.
  always_comb begin
    if (state == SEND && bit_idx == 4'd0) expired = (timer == START_LAST);
    else                                  expired = (timer == BIT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (tx_start) state_n = INHIBIT;
      INHIBIT:   if (timer == INHIBIT_LAST) state_n = RELEASE;
      RELEASE:   state_n = SEND;
      SEND: begin
        if (clk_fall) begin
          if (bit_idx == 4'd9) state_n = ACK;
        end else if (expired) begin
          state_n = IDLE;
        end
      end
      ACK: begin
        if (clk_fall)     state_n = WAIT_IDLE;
        else if (expired) state_n = IDLE;
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) state_n = IDLE;
        else if (expired)          state_n = IDLE;
      end
      default:   state_n = IDLE;
    endcase
  end

  always_comb begin
    frame_n    = frame;
    bit_idx_n  = bit_idx;
    timer_n    = timer + 1'b1;
    ack_ok_n   = ack_ok;
    busy_n     = tx_busy;
    done_n     = 1'b0;
    error_n    = 1'b0;
    clk_low_n  = ps2_clk_drive_low;
    data_low_n = ps2_data_drive_low;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (tx_start) begin
          frame_n   = {1'b1, odd_parity(tx_data), tx_data};
          busy_n    = 1'b1;
          clk_low_n = 1'b1;
        end
      end
      INHIBIT: begin
        if (timer == INHIBIT_LAST) data_low_n = 1'b1;
      end
      RELEASE: begin
        clk_low_n = 1'b0;
        timer_n   = '0;
        bit_idx_n = '0;
      end
      SEND: begin
        if (clk_fall) begin
          data_low_n = ~frame[bit_idx];
          timer_n    = '0;
          bit_idx_n  = bit_idx + 4'd1;
        end else if (expired) begin
          clk_low_n  = 1'b0;
          data_low_n = 1'b0;
          busy_n     = 1'b0;
          error_n    = 1'b1;
        end
      end
      ACK: begin
        if (clk_fall) begin
          ack_ok_n = ~data_sync;
          timer_n  = '0;
        end else if (expired) begin
          clk_low_n  = 1'b0;
          data_low_n = 1'b0;
          busy_n     = 1'b0;
          error_n    = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          busy_n  = 1'b0;
          done_n  = ack_ok;
          error_n = ~ack_ok;
        end else if (expired) begin
          clk_low_n  = 1'b0;
          data_low_n = 1'b0;
          busy_n     = 1'b0;
          error_n    = 1'b1;
        end
      end
      default: begin
        clk_low_n  = 1'b0;
        data_low_n = 1'b0;
        busy_n     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame              <= '0;
      bit_idx            <= '0;
      timer              <= '0;
      ack_ok             <= 1'b0;
      tx_busy            <= 1'b0;
      tx_done            <= 1'b0;
      tx_error           <= 1'b0;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
    end else begin
      frame              <= frame_n;
      bit_idx            <= bit_idx_n;
      timer              <= timer_n;
      ack_ok             <= ack_ok_n;
      tx_busy            <= busy_n;
      tx_done            <= done_n;
      tx_error           <= error_n;
      ps2_clk_drive_low  <= clk_low_n;
      ps2_data_drive_low <= data_low_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard on the
// open-drain lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 20;
  localparam int unsigned STO = 200;
  localparam int unsigned BTO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_drive_low | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (STO),
    .BIT_TIMEOUT_CYCLES   (BTO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .tx_data            (tx_data),
    .tx_start           (tx_start),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .tx_error           (tx_error),
    .ps2_clk_in         (ps2_clk_in),
    .ps2_data_in        (ps2_data_in),
    .ps2_clk_drive_low  (ps2_clk_drive_low),
    .ps2_data_drive_low (ps2_data_drive_low)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled 1 time unit after each falling clk edge.
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   clk_run = 0, last_clk_run = 0;
  int   since_rel = 0, since_fall = 0;
  int   err_since_rel = -1, err_since_fall = -1;
  logic prev_clk_low = 1'b0, prev_data_low = 1'b0, prev_pin_clk = 1'b1;
  logic data_low_at_rel = 1'b0;

  always @(negedge clk) begin
    #1;
    since_rel++;
    since_fall++;
    if (prev_clk_low && !ps2_clk_drive_low) begin
      since_rel       = 0;
      last_clk_run    = clk_run;
      data_low_at_rel = prev_data_low;
    end
    if (prev_pin_clk && !ps2_clk_in) since_fall = 0;
    clk_run = ps2_clk_drive_low ? clk_run + 1 : 0;
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_since_rel  = since_rel;
      err_since_fall = since_fall;
    end
    if (tx_done && tx_error) both_cnt++;
    prev_clk_low  = ps2_clk_drive_low;
    prev_data_low = ps2_data_drive_low;
    prev_pin_clk  = ps2_clk_in;
  end

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Keyboard model: 40 clk per half period, samples data on its rising edges.
  task automatic dev_run(input int n_edges, input bit do_ack, output logic [9:0] bits);
    int k = 0;
    bits = '0;
    while (!(ps2_clk_in && !ps2_data_in && !ps2_clk_drive_low) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_eq("dev_sees_start", 32'(k < 500), 1);
    if (k >= 500) return;
    repeat (10) @(negedge clk);
    for (int i = 0; i < n_edges; i++) begin
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i < 10) bits[i] = ps2_data_in;
      if (i == 9 && do_ack) begin
        repeat (20) @(negedge clk);
        dev_data_low = 1'b1;
        repeat (20) @(negedge clk);
      end else if (i == 10) begin
        repeat (20) @(negedge clk);
        dev_data_low = 1'b0;
        repeat (20) @(negedge clk);
      end else begin
        repeat (40) @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (tx_busy === 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_idle_in_time"}, 32'(k < 2000), 1);
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] par_data [2] = '{8'h00, 8'h01};
  logic       par_exp  [2] = '{1'b1, 1'b0};

  initial begin
    logic [9:0] bits;
    int d0, e0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_done", tx_done, 0);
    check_eq("rst_error", tx_error, 0);
    check_eq("rst_clk_low", ps2_clk_drive_low, 0);
    check_eq("rst_data_low", ps2_data_drive_low, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Set-LEDs command, full handshake with ACK.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(CMD_SET_LEDS);
    dev_run(11, 1'b1, bits);
    wait_idle("ed");
    check_eq("ed_data", bits[7:0], 8'hED);
    check_eq("ed_parity", bits[8], 1);
    check_eq("ed_stop", bits[9], 1);
    check_eq("ed_done", done_cnt - d0, 1);
    check_eq("ed_err", err_cnt - e0, 0);
    check_eq("ed_clk_low_cycles", last_clk_run, INH + 1);
    check_eq("ed_start_before_release", data_low_at_rel, 1);
    check_eq("ed_busy_end", tx_busy, 0);
    check_eq("ed_clk_low_end", ps2_clk_drive_low, 0);
    check_eq("ed_data_low_end", ps2_data_drive_low, 0);

    // Parity corner cases.
    for (int t = 0; t < 2; t++) begin
      d0 = done_cnt;
      start_tx(par_data[t]);
      dev_run(11, 1'b1, bits);
      wait_idle("par");
      check_eq("par_data", bits[7:0], par_data[t]);
      check_eq("par_bit", bits[8], par_exp[t]);
      check_eq("par_done", done_cnt - d0, 1);
    end

    // Device never clocks after release.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h55);
    wait_idle("sto");
    check_eq("sto_err", err_cnt - e0, 1);
    check_eq("sto_done", done_cnt - d0, 0);
    check_eq("sto_delay", err_since_rel, STO);
    check_eq("sto_clk_low", ps2_clk_drive_low, 0);
    check_eq("sto_data_low", ps2_data_drive_low, 0);

    // Device stops after the 4th falling edge.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(CMD_SET_LEDS);
    dev_run(4, 1'b0, bits);
    wait_idle("bto");
    check_eq("bto_err", err_cnt - e0, 1);
    check_eq("bto_done", done_cnt - d0, 0);
    check_eq("bto_delay", err_since_fall, BTO + 2);
    check_eq("bto_clk_low", ps2_clk_drive_low, 0);
    check_eq("bto_data_low", ps2_data_drive_low, 0);

    // Device leaves data high at the 11th edge.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(CMD_RESET);
    dev_run(11, 1'b0, bits);
    wait_idle("nak");
    check_eq("nak_data", bits[7:0], 8'hFF);
    check_eq("nak_err", err_cnt - e0, 1);
    check_eq("nak_done", done_cnt - d0, 0);

    // Second request mid-frame is ignored.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(CMD_SET_LEDS);
    fork
      dev_run(11, 1'b1, bits);
      begin
        repeat (300) @(negedge clk);
        tx_data  = CMD_RESET;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    wait_idle("ign");
    check_eq("ign_frame", bits, 10'b11_1110_1101);
    check_eq("ign_done", done_cnt - d0, 1);
    check_eq("ign_err", err_cnt - e0, 0);
    repeat (50) @(negedge clk);
    check_eq("ign_not_queued", tx_busy, 0);

    // Asynchronous reset in the middle of SEND.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF0);
    dev_run(4, 1'b0, bits);
    check_eq("rstmid_data_low_before", ps2_data_drive_low, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rstmid_clk_low", ps2_clk_drive_low, 0);
    check_eq("rstmid_data_low", ps2_data_drive_low, 0);
    check_eq("rstmid_busy", tx_busy, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("rstmid_no_done", done_cnt - d0, 0);
    check_eq("rstmid_no_err", err_cnt - e0, 0);

    d0 = done_cnt; e0 = err_cnt;
    start_tx(CMD_RESET);
    dev_run(11, 1'b1, bits);
    wait_idle("post");
    check_eq("post_frame", bits, 10'b11_1111_1111);
    check_eq("post_done", done_cnt - d0, 1);
    check_eq("post_err", err_cnt - e0, 0);

    check_eq("done_error_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
